// File: rtl/dispatch_pkg.sv
// Shared types and constants for the one-hot line dispatcher.
// Holds the FSM state encoding, line-count derivation and the index decode helper.
package dispatch_pkg;

    localparam int IDX_W          = 3;
    localparam int N_LINES        = 1 << IDX_W;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam int DEF_TIMEOUT    = 15;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ASSERT = 2'd1,
        GAP    = 2'd2
    } state_t;

    // Decode a line index into its one-hot grant vector.
    function automatic logic [N_LINES-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
        logic [N_LINES-1:0] vec;
        vec      = '0;
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/dispatch_sync_fifo.sv
// Small synchronous FIFO buffering pending line indices.
// Push into a full queue and pop from an empty one are silently ignored.
module sync_fifo #(
    parameter int WIDTH = 3,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (count_r == CNT_W'(DEPTH));
    assign empty  = (count_r == {CNT_W{1'b0}});
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign rdata  = mem_r[rd_ptr_r];
    assign count  = count_r;

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; power-of-two depth lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + 1'b1;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + 1'b1;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/onehot_dispatch_3to8.sv
// Queued index-to-one-hot dispatcher: holds each granted line until its ack or a timeout,
// with one idle cycle between consecutive grants.
module onehot_dispatch_3to8
    import dispatch_pkg::*;
#(
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int TIMEOUT    = DEF_TIMEOUT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [IDX_W-1:0]   in_idx,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [N_LINES-1:0] ack,
    output logic [N_LINES-1:0] out_onehot,
    output logic               busy,
    output logic               timeout
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_t             state_r, state_nxt_s;
    logic [TMR_W-1:0]   timer_r, timer_nxt_s;
    logic [IDX_W-1:0]   cur_idx_r, cur_idx_nxt_s;
    logic [N_LINES-1:0] onehot_r, onehot_nxt_s;
    logic               timeout_r, timeout_nxt_s;

    logic               push_s;
    logic               pop_s;
    logic [IDX_W-1:0]   head_s;
    logic               full_s;
    logic               empty_s;
    logic [CNT_W-1:0]   count_s;

    assign in_ready = rst_n && (count_s < CNT_W'(FIFO_DEPTH));
    assign push_s   = in_valid && in_ready;

    sync_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata (in_idx),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s),
        .count (count_s)
    );

    // Next-state, timer and grant decode.
    always_comb begin
        state_nxt_s   = state_r;
        timer_nxt_s   = timer_r;
        cur_idx_nxt_s = cur_idx_r;
        onehot_nxt_s  = onehot_r;
        timeout_nxt_s = 1'b0;
        pop_s         = 1'b0;
        case (state_r)
            IDLE, GAP: begin
                if (!empty_s) begin
                    pop_s         = 1'b1;
                    cur_idx_nxt_s = head_s;
                    onehot_nxt_s  = idx_to_onehot(head_s);
                    timer_nxt_s   = '0;
                    state_nxt_s   = ASSERT;
                end else begin
                    onehot_nxt_s  = '0;
                    state_nxt_s   = IDLE;
                end
            end
            ASSERT: begin
                // Only the granted line's ack matters; ack beats an expiring timer.
                if (ack[cur_idx_r]) begin
                    onehot_nxt_s  = '0;
                    state_nxt_s   = GAP;
                end else if (timer_r == TMR_LAST) begin
                    onehot_nxt_s  = '0;
                    timeout_nxt_s = 1'b1;
                    state_nxt_s   = GAP;
                end else begin
                    timer_nxt_s   = timer_r + 1'b1;
                end
            end
            default: begin
                onehot_nxt_s = '0;
                state_nxt_s  = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            timer_r   <= '0;
            cur_idx_r <= '0;
            onehot_r  <= '0;
            timeout_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            timer_r   <= timer_nxt_s;
            cur_idx_r <= cur_idx_nxt_s;
            onehot_r  <= onehot_nxt_s;
            timeout_r <= timeout_nxt_s;
        end
    end

    assign out_onehot = onehot_r;
    assign timeout    = timeout_r;
    assign busy       = rst_n && ((state_r != IDLE) || !empty_s);

endmodule

// File: tb/tb_onehot_dispatch_3to8.sv
// Directed self-checking bench for onehot_dispatch_3to8.
module tb_onehot_dispatch_3to8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] in_idx;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] ack;
    logic [7:0] out_onehot;
    logic       busy;
    logic       timeout;

    int n_checks = 0;
    int n_fail   = 0;

    onehot_dispatch_3to8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_idx     (in_idx),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ack        (ack),
        .out_onehot (out_onehot),
        .busy       (busy),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_idx(input logic [2:0] i);
        in_idx   = i;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Ack the currently held line, expect the zero gap, then expect the next grant.
    task automatic ack_then_expect(input logic [7:0] line, input logic [7:0] next, input string tag);
        ack = line;
        tick();
        check_eq({tag, "_gap"}, {24'd0, out_onehot}, 32'h00);
        ack = 8'h00;
        tick();
        check_eq({tag, "_next"}, {24'd0, out_onehot}, {24'd0, next});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi;
        bit early_to;

        rst_n    = 1'b0;
        in_idx   = 3'd0;
        in_valid = 1'b0;
        ack      = 8'h00;
        tick();
        tick();
        check_eq("rst_onehot", {24'd0, out_onehot}, 32'h00);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_ready", {31'd0, in_ready}, 32'd0);
        check_eq("rst_timeout", {31'd0, timeout}, 32'd0);
        rst_n = 1'b1;
        #1;
        check_eq("post_rst_ready", {31'd0, in_ready}, 32'd1);

        // Single request: idx 5 -> line 5 one edge after acceptance.
        push_idx(3'd5);
        check_eq("t1_latency", {24'd0, out_onehot}, 32'h00);
        check_eq("t1_busy_q", {31'd0, busy}, 32'd1);
        tick();
        check_eq("t1_grant", {24'd0, out_onehot}, 32'h20);
        ack = 8'h20;
        tick();
        check_eq("t1_drop", {24'd0, out_onehot}, 32'h00);
        check_eq("t1_busy_gap", {31'd0, busy}, 32'd1);
        ack = 8'h00;
        tick();
        check_eq("t1_busy_idle", {31'd0, busy}, 32'd0);

        // Queue fill while line 6 is held.
        push_idx(3'd6);
        tick();
        check_eq("t2_hold6", {24'd0, out_onehot}, 32'h40);
        in_valid = 1'b1;
        in_idx = 3'd2; tick();
        in_idx = 3'd7; tick();
        in_idx = 3'd0; tick();
        in_idx = 3'd3; tick();
        in_valid = 1'b0;
        check_eq("t2_full_ready", {31'd0, in_ready}, 32'd0);
        check_eq("t2_still6", {24'd0, out_onehot}, 32'h40);
        push_idx(3'd1);
        check_eq("t2_refused_ready", {31'd0, in_ready}, 32'd0);
        ack_then_expect(8'h40, 8'h04, "t2_g2");
        check_eq("t2_ready_after_pop", {31'd0, in_ready}, 32'd1);
        ack_then_expect(8'h04, 8'h80, "t2_g7");
        ack_then_expect(8'h80, 8'h01, "t2_g0");
        ack_then_expect(8'h01, 8'h08, "t2_g3");
        ack_then_expect(8'h08, 8'h00, "t2_empty");
        check_eq("t2_busy_end", {31'd0, busy}, 32'd0);

        // Timeout: idx 1 never acked.
        push_idx(3'd1);
        tick();
        hi = 0;
        early_to = 1'b0;
        if (out_onehot == 8'h02) hi = 1;
        while (hi > 0 && hi < 40) begin
            tick();
            if (out_onehot == 8'h02) begin
                hi++;
                if (timeout) early_to = 1'b1;
            end else begin
                break;
            end
        end
        check_eq("t3_high_cycles", hi, 32'd15);
        check_eq("t3_early_pulse", {31'd0, early_to}, 32'd0);
        check_eq("t3_pulse", {31'd0, timeout}, 32'd1);
        check_eq("t3_dropped", {24'd0, out_onehot}, 32'h00);
        tick();
        check_eq("t3_pulse_end", {31'd0, timeout}, 32'd0);
        check_eq("t3_idle", {31'd0, busy}, 32'd0);

        // Wrong-line ack is ignored.
        push_idx(3'd4);
        tick();
        ack = 8'hEF;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("t4_wrong_ack", {24'd0, out_onehot}, 32'h10);
        end
        ack = 8'h10;
        tick();
        check_eq("t4_right_ack", {24'd0, out_onehot}, 32'h00);
        ack = 8'h00;
        tick();

        // Ack on the final timer cycle wins over timeout.
        push_idx(3'd2);
        tick();
        repeat (14) tick();
        check_eq("t5_held14", {24'd0, out_onehot}, 32'h04);
        ack = 8'h04;
        tick();
        check_eq("t5_drop", {24'd0, out_onehot}, 32'h00);
        check_eq("t5_no_timeout", {31'd0, timeout}, 32'd0);
        ack = 8'h00;
        tick();

        // Reset mid-operation discards the held line and the queue.
        push_idx(3'd3);
        tick();
        push_idx(3'd1);
        push_idx(3'd6);
        check_eq("t6_hold3", {24'd0, out_onehot}, 32'h08);
        rst_n = 1'b0;
        tick();
        check_eq("t6_rst_onehot", {24'd0, out_onehot}, 32'h00);
        check_eq("t6_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("t6_rst_ready", {31'd0, in_ready}, 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("t6_no_stale", {24'd0, out_onehot}, 32'h00);
            check_eq("t6_idle_busy", {31'd0, busy}, 32'd0);
        end
        push_idx(3'd0);
        tick();
        check_eq("t6_new_grant", {24'd0, out_onehot}, 32'h01);
        ack = 8'h01;
        tick();
        ack = 8'h00;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
